timer_arbiter: RTL and testbench

- Shares one timer instance between N_REQ requesters (e.g. motor step, debounce and PWM-dead-time logic).
- Picks requesters round-robin, loads the winner's count, and runs the timer's start/done handshake to completion.
- Returns a one-cycle ack to the winner.
- Sits between the client blocks and a single timer, which is instantiated alongside it at the same level.

---
 rtl/timer_pkg.sv | 14 +
 rtl/rr_pick.sv | 33 +++
 rtl/timer_arbiter.sv | 84 ++++++++
 tb/tb_timer_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and default sizes for the timer arbiter slice
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd1,
    ARM       = 3'd2,
    WAIT_DONE = 3'd3,
    RELEASE   = 3'd4
  } arb_state_t;

  localparam int TIMER_CW  = 32;
  localparam int ARB_N_REQ = 4;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector, search starts just after last_grant
module rr_pick #(
  parameter int N_REQ = 4,
  localparam int IW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic             valid,
  output logic [IW-1:0]    sel
);

  localparam logic [IW:0] NR = (IW+1)'(N_REQ);

  logic [IW:0] pos;
  logic        found;

  always_comb begin
    valid = |req;
    sel   = '0;
    found = 1'b0;
    pos   = '0;
    // k = N_REQ lands back on last_grant, so it is only picked when it is the sole requester
    for (int k = 1; k <= N_REQ; k++) begin
      pos = {1'b0, last_grant} + (IW+1)'(k);
      if (pos >= NR) pos = pos - NR;
      if (!found && req[pos[IW-1:0]]) begin
        sel   = pos[IW-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// rtl/timer_arbiter.sv - round-robin arbiter sharing one timer between N_REQ requesters
module timer_arbiter
  import timer_pkg::*;
#(
  parameter int N_REQ = ARB_N_REQ,
  parameter int CW    = TIMER_CW,
  localparam int IW   = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*CW-1:0] req_count,
  output logic [N_REQ-1:0]    ack,
  output logic                busy,
  output logic [IW-1:0]       grant_id,
  output logic                timer_start,
  output logic [CW-1:0]       timer_count,
  input  logic                timer_done
);

  arb_state_t       state, state_n;
  logic [IW-1:0]    last_grant, last_n, grant_n, pick_sel;
  logic             pick_valid;
  logic [CW-1:0]    count_n;
  logic [N_REQ-1:0] ack_n;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req        (req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .sel        (pick_sel)
  );

  // Decoded from the state register only, so req never reaches the timer combinationally
  assign busy        = (state != IDLE);
  assign timer_start = (state == ARM) || (state == WAIT_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_grant  <= IW'(N_REQ - 1);
      grant_id    <= '0;
      timer_count <= '0;
      ack         <= '0;
    end else begin
      state       <= state_n;
      last_grant  <= last_n;
      grant_id    <= grant_n;
      timer_count <= count_n;
      ack         <= ack_n;
    end
  end

  always_comb begin
    state_n = state;
    last_n  = last_grant;
    grant_n = grant_id;
    count_n = timer_count;
    ack_n   = '0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_n = pick_sel;
          count_n = req_count[int'(pick_sel)*CW +: CW];
          state_n = ARM;
        end
      end
      ARM: state_n = WAIT_DONE;
      WAIT_DONE: begin
        if (timer_done) begin
          ack_n[grant_id] = 1'b1;
          last_n          = grant_id;
          state_n         = RELEASE;
        end
      end
      RELEASE: begin
        // Hold off re-arbitration until the timer is back in READY
        if (!timer_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// tb/tb_timer_arbiter.sv - randomized scoreboard bench for timer_arbiter with a behavioural timer
module tb_timer_arbiter;
  import timer_pkg::*;

  localparam int N  = 4;
  localparam int CW = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*CW-1:0] req_count;
  logic [N-1:0]    ack;
  logic            busy;
  logic [IW-1:0]   grant_id;
  logic            timer_start;
  logic [CW-1:0]   timer_count;
  logic            timer_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  timer_arbiter #(.N_REQ(N), .CW(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_count   (req_count),
    .ack         (ack),
    .busy        (busy),
    .grant_id    (grant_id),
    .timer_start (timer_start),
    .timer_count (timer_count),
    .timer_done  (timer_done)
  );

  // Behavioural timer: READY -> COUNTING on start, done after count+1 cycles, held until start drops
  int            t_ph;
  logic [CW-1:0] t_cnt;
  logic          t_done;
  logic          stale;
  assign timer_done = t_done | stale;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_ph <= 0; t_cnt <= '0; t_done <= 1'b0;
    end else begin
      case (t_ph)
        0: if (timer_start) begin t_cnt <= timer_count; t_ph <= 1; end
        1: if (t_cnt == 0) begin t_done <= 1'b1; t_ph <= 2; end else t_cnt <= t_cnt - 1;
        default: if (!timer_start) begin t_done <= 1'b0; t_ph <= 0; end
      endcase
    end
  end

  // Reference model: phase 0 idle, 1 arm, 2 waiting for done, 3 waiting for done to fall
  typedef struct { int id; logic [CW-1:0] cnt; } exp_t;
  exp_t          exp_q[$];
  int            m_ph, m_last, m_id;
  logic [CW-1:0] m_cnt;
  logic          m_ack_due;

  function automatic int rr_ref(logic [N-1:0] r, int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ph = 0; m_last = N - 1; m_id = 0; m_cnt = '0; m_ack_due = 1'b0;
      exp_q.delete();
    end else begin
      m_ack_due = 1'b0;
      case (m_ph)
        0: if (req != 0) begin
          m_id  = rr_ref(req, m_last);
          m_cnt = req_count[m_id*CW +: CW];
          exp_q.push_back('{m_id, m_cnt});
          m_ph  = 1;
        end
        1: m_ph = 2;
        2: if (timer_done) begin m_ack_due = 1'b1; m_last = m_id; m_ph = 3; end
        default: if (!timer_done) m_ph = 0;
      endcase
    end
  end

  task automatic chk(string name, logic [CW-1:0] act, logic [CW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle output checks plus scoreboard pop on every ack
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      exp_t e;
      chk("busy", busy, CW'(m_ph != 0));
      chk("timer_start", timer_start, CW'(m_ph == 1 || m_ph == 2));
      chk("grant_id", grant_id, CW'(m_id));
      if (m_ph != 0) chk("timer_count_stable", timer_count, m_cnt);
      chk("ack_timing", CW'(ack != 0), CW'(m_ack_due));
      if (ack != 0) begin
        if (exp_q.size() == 0) begin
          chk("ack_unexpected", CW'(ack), 0);
        end else begin
          e = exp_q.pop_front();
          chk("ack_onehot", CW'(ack), CW'(1) << e.id);
          chk("ack_count", timer_count, e.cnt);
        end
      end
    end
  end

  bit keep0 = 1'b0;
  bit rnd   = 1'b0;

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (ack[i] && !(keep0 && i == 0)) req[i] = 1'b0;
      if (rnd) begin
        if (!req[i] && $urandom_range(0, 5) == 0) begin
          req_count[i*CW +: CW] = ($urandom_range(0, 9) == 0) ? 32'd20 : CW'($urandom_range(0, 7));
          req[i] = 1'b1;
        end else if (req[i] && $urandom_range(0, 60) == 0) begin
          req[i] = 1'b0;
        end else if (req[i] && $urandom_range(0, 7) == 0) begin
          req_count[i*CW +: CW] = CW'($urandom_range(0, 7));
        end
      end
    end
    stale = (m_ph <= 1) && ($urandom_range(0, 7) == 0);
  endtask

  task automatic wait_idle(string name, int bound);
    int n = 0;
    while (!(req == 0 && m_ph == 0) && n < bound) begin step(); n++; end
    if (n >= bound) chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic wait_ph(string name, int p, int bound);
    int n = 0;
    while (m_ph != p && n < bound) begin step(); n++; end
    if (n >= bound) chk({name, "_timeout"}, 1, 0);
  endtask

  initial begin
    reset = 1'b0; req = '0; req_count = '0; stale = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ack", CW'(ack), 0);
    chk("rst_grant_id", CW'(grant_id), 0);
    chk("rst_timer_start", timer_start, 0);
    chk("rst_timer_count", timer_count, 0);
    reset = 1'b1;

    req_count[0*CW +: CW] = 10; req = 4'b0001;
    wait_idle("single", 100);

    for (int i = 0; i < N; i++) req_count[i*CW +: CW] = 3;
    req = 4'b1011;
    wait_idle("contention", 200);

    keep0 = 1'b1;
    req_count[0*CW +: CW] = 5; req = 4'b0001;
    wait_ph("fair_arm", 2, 50);
    req_count[2*CW +: CW] = 4; req[2] = 1'b1;
    repeat (60) step();
    keep0 = 1'b0;
    wait_idle("fairness", 200);

    req_count[2*CW +: CW] = 0; req = 4'b0100;
    wait_idle("count0", 100);

    req_count[1*CW +: CW] = 6; req = 4'b0010;
    wait_ph("withdraw_arm", 1, 50);
    step();
    req[1] = 1'b0;
    wait_ph("withdraw_done", 0, 100);

    rnd = 1'b1;
    repeat (2500) step();
    rnd = 1'b0;
    wait_idle("random_drain", 500);

    req_count[2*CW +: CW] = 20; req = 4'b0100;
    wait_ph("reset_wait", 2, 50);
    repeat (3) step();
    #2 reset = 1'b0;
    #1;
    chk("midrst_timer_start", timer_start, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ack", CW'(ack), 0);
    req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    req_count[3*CW +: CW] = 5; req = 4'b1000;
    wait_idle("post_reset", 100);
    repeat (3) step();
    chk("scoreboard_empty", CW'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
